// File: rtl/uart_rx_sniffer_pkg.sv
// Shared states and oversampling constants for the UART receive sniffer.
// The PARITY state exists only when UART_RX_SNIFFER_PARITY_EN is defined.
package uart_rx_sniffer_pkg;

    localparam int OversampleRate = 16;
    localparam int MidTick        = 8;

`ifdef UART_RX_SNIFFER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;
`endif

endpackage

// File: rtl/uart_rx_sniffer_fifo.sv
// Received-byte buffer: power-of-two ring with occupancy counter.
// A push on a full buffer is accepted only when a pop frees the head slot.
module uart_rx_sniffer_fifo
    import uart_rx_sniffer_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] data_o
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [7:0]  mem_q [Depth];
    logic [7:0]  mem_d [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || pop_i);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_sniffer.sv
// 16x-oversampling UART receiver feeding a byte FIFO (8N1 by default).
// Define UART_RX_SNIFFER_PARITY_EN for 8-bit + parity + 1 stop frames.
module uart_rx_sniffer
    import uart_rx_sniffer_pkg::*;
#(
    parameter int DivW      = 16,
    parameter int FifoDepth = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [DivW-1:0] div_i,
    input  logic            rx_i,
    output logic [7:0]      data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            frame_err_o,
    output logic            overrun_o,
    output logic            busy_o
`ifdef UART_RX_SNIFFER_PARITY_EN
    ,
    input  logic            parity_odd_i,
    output logic            parity_err_o
`endif
);

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_sync_q;
    logic [1:0]      fill_q, fill_d;
    logic            prev_q, prev_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [DivW-1:0] eff_div;
    logic [3:0]      tcnt_q, tcnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            busy_q, busy_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            tick;
    logic            bit_done;
    logic            fall;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
`ifdef UART_RX_SNIFFER_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    assign pop         = valid_o && ready_i;
    assign valid_o     = !fifo_empty;
    assign busy_o      = busy_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef UART_RX_SNIFFER_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

    always_comb begin
        eff_div   = (div_i == '0) ? DivW'(1) : div_i;
        tick      = (div_cnt_q == '0);
        div_cnt_d = tick ? eff_div - DivW'(1) : div_cnt_q - DivW'(1);
        bit_done  = tick && (tcnt_q == 4'(OversampleRate - 1));
        // Synchronizer output is trusted only once both flops hold line data.
        fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        prev_d = (fill_q == 2'd2) ? rx_sync_q : 1'b0;
        fall   = (fill_q == 2'd2) && prev_q && !rx_sync_q;

        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_SNIFFER_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d   = START;
                    div_cnt_d = eff_div - DivW'(1);
                    tcnt_d    = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt_q == 4'(MidTick - 1)) begin
                        tcnt_d  = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                end
                if (bit_done) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_SNIFFER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_SNIFFER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                end
                if (bit_done) begin
                    par_bad_d = ((^shift_q) ^ rx_sync_q) != parity_odd_i;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                end
                if (bit_done) begin
                    state_d = IDLE;
`ifdef UART_RX_SNIFFER_PARITY_EN
                    if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else if (rx_sync_q) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
`else
                    if (rx_sync_q) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            fill_q       <= '0;
            prev_q       <= 1'b0;
            div_cnt_q    <= '0;
            state_q      <= IDLE;
            tcnt_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_SNIFFER_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            fill_q       <= fill_d;
            prev_q       <= prev_d;
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_SNIFFER_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_rx_sniffer_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (data_o)
    );

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Scoreboard bench for uart_rx_sniffer: bytes queued on send, compared on pop.
// Parity scenarios are built when UART_RX_SNIFFER_PARITY_EN is defined.
module tb_uart_rx_sniffer;

    localparam int Depth   = 8;
    localparam int Div     = 4;
    localparam int BitClks = 16 * Div;
`ifdef UART_RX_SNIFFER_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    // Stop-bit sample: 2 sync + 1 edge cycle, 8 ticks, then one bit per 16 ticks.
    localparam int StopClk = 3 + 8 * Div + BitClks * (FrameBits - 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        ready = 1'b0;
    logic [15:0] div_s = 16'(Div);
    logic [7:0]  data;
    logic        valid;
    logic        ferr;
    logic        ovr;
    logic        busy;
`ifdef UART_RX_SNIFFER_PARITY_EN
    logic        par_odd = 1'b1;
    logic        perr;
`endif

    int checks = 0;
    int failures = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_sniffer #(
        .DivW      (16),
        .FifoDepth (Depth)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .div_i        (div_s),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .busy_o       (busy)
`ifdef UART_RX_SNIFFER_PARITY_EN
        ,
        .parity_odd_i (par_odd),
        .parity_err_o (perr)
`endif
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data);
            if (ferr) n_ferr++;
            if (ovr) n_ovr++;
`ifdef UART_RX_SNIFFER_PARITY_EN
            if (perr) n_perr++;
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            cyc(BitClks);
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
`ifdef UART_RX_SNIFFER_PARITY_EN
        send_bits({stop_b, (^b) ^ par_odd, b, 1'b0}, 11);
`else
        send_bits({1'b0, stop_b, b, 1'b0}, 10);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef UART_RX_SNIFFER_PARITY_EN
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", perr); end
`endif
        rst_n = 1'b1;
        cyc(8);
    endtask

    task automatic test_basic();
        int f0, o0, p0;
        logic [7:0] g;
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        ready = 1'b0;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                cyc(StopClk - 6);
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_early got=%b exp=0", valid); end
                cyc(10);
                checks++; if (valid !== 1'b1) begin failures++; $display("FAIL basic_valid_late got=%b exp=1", valid); end
                checks++; if (data !== 8'h55) begin failures++; $display("FAIL basic_data got=%h exp=55", data); end
            end
        join
        ready = 1'b1;
        for (int k = 0; k < 200 && got_q.size() < 1; k++) cyc(1);
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL basic_missing got=none exp=%h", exp_q.pop_front());
            end else begin
                g = got_q.pop_front();
                if (g !== exp_q[0]) begin failures++; $display("FAIL basic_byte got=%h exp=%h", g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", n_ferr - f0); end
        checks++; if (n_ovr - o0 != 0) begin failures++; $display("FAIL basic_ovr got=%0d exp=0", n_ovr - o0); end
        checks++; if (n_perr - p0 != 0) begin failures++; $display("FAIL basic_perr got=%0d exp=0", n_perr - p0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [5] = '{8'h00, 8'hFF, 8'hC3, 8'h3C, 8'h81};
        logic [7:0] g;
        ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pat[i]);
            send_frame(pat[i], 1'b1);
        end
        for (int k = 0; k < 400 && got_q.size() < 5; k++) cyc(1);
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL b2b_missing got=none exp=%h", exp_q.pop_front());
            end else begin
                g = got_q.pop_front();
                if (g !== exp_q[0]) begin failures++; $display("FAIL b2b_byte got=%h exp=%h", g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = n_ferr;
        ready = 1'b1;
        got_q.delete();
        rx = 1'b0;
        cyc(19);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        cyc(26);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_idle got=%b exp=0", busy); end
        cyc(BitClks * 12);
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - f0); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_push got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = n_ferr;
        ready = 1'b1;
        got_q.delete();
        send_frame(8'hA3, 1'b0);
        cyc(BitClks);
        checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", n_ferr - f0); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_push got=%0d exp=0", got_q.size()); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", valid); end
    endtask

    task automatic test_overrun();
        int o0, occ, exp_ovr;
        logic [7:0] g;
        o0 = n_ovr; occ = 0; exp_ovr = 0;
        ready = 1'b0;
        got_q.delete();
        for (int i = 0; i <= Depth; i++) begin
            if (occ < Depth) begin
                exp_q.push_back(8'(i));
                occ++;
            end else begin
                exp_ovr++;
            end
            send_frame(8'(i), 1'b1);
        end
        cyc(BitClks);
        checks++; if (n_ovr - o0 != exp_ovr) begin failures++; $display("FAIL ovr_pulses got=%0d exp=%0d", n_ovr - o0, exp_ovr); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL ovr_head got=%h exp=00", data); end
        ready = 1'b1;
        for (int k = 0; k < 200 && got_q.size() < Depth; k++) cyc(1);
        cyc(5);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL ovr_missing got=none exp=%h", exp_q.pop_front());
            end else begin
                g = got_q.pop_front();
                if (g !== exp_q[0]) begin failures++; $display("FAIL ovr_byte got=%h exp=%h", g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        logic [7:0] g;
        ready = 1'b1;
        got_q.delete();
        send_bits({1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, 5);
        rx = 1'b0;
        cyc(20);
        rst_n = 1'b0;
        cyc(4);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        f0 = n_ferr;
        cyc(BitClks * 4 - 24);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_low_line got=%b exp=0", busy); end
        rx = 1'b1;
        cyc(BitClks * 2);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        for (int k = 0; k < 200 && got_q.size() < 1; k++) cyc(1);
        cyc(BitClks);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", got_q.size()); end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL midrst_ferr got=%0d exp=0", n_ferr - f0); end
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL midrst_missing got=none exp=%h", exp_q.pop_front());
            end else begin
                g = got_q.pop_front();
                if (g !== exp_q[0]) begin failures++; $display("FAIL midrst_byte got=%h exp=%h", g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask

`ifdef UART_RX_SNIFFER_PARITY_EN
    task automatic test_parity();
        int p0, f0;
        logic [7:0] g;
        par_odd = 1'b1;
        ready = 1'b1;
        got_q.delete();
        p0 = n_perr; f0 = n_ferr;
        send_bits({1'b1, 1'b1, 8'h01, 1'b0}, 11);
        cyc(BitClks);
        checks++; if (n_perr - p0 != 1) begin failures++; $display("FAIL par_bad_pulse got=%0d exp=1", n_perr - p0); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL par_bad_push got=%0d exp=0", got_q.size()); end
        p0 = n_perr;
        send_bits({1'b0, 1'b1, 8'h01, 1'b0}, 11);
        cyc(BitClks);
        checks++; if (n_perr - p0 != 1) begin failures++; $display("FAIL par_prio_perr got=%0d exp=1", n_perr - p0); end
        checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL par_prio_ferr got=%0d exp=0", n_ferr - f0); end
        p0 = n_perr;
        exp_q.push_back(8'h01);
        send_bits({1'b1, 1'b0, 8'h01, 1'b0}, 11);
        for (int k = 0; k < 200 && got_q.size() < 1; k++) cyc(1);
        checks++; if (n_perr - p0 != 0) begin failures++; $display("FAIL par_good_perr got=%0d exp=0", n_perr - p0); end
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL par_missing got=none exp=%h", exp_q.pop_front());
            end else begin
                g = got_q.pop_front();
                if (g !== exp_q[0]) begin failures++; $display("FAIL par_byte got=%h exp=%h", g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_SNIFFER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
